mod_inverse_unit: RTL and testbench

- Sequential modular-inverse engine; computes x such that (a*x) % m == 1 for odd modulus m.
- Undoes the modular multiply performed by the combinational modular ALU, e.g. deriving decryption exponents and multiplicative inverses.
- Iterative binary extended-Euclid algorithm: shifts and subtracts only, no divider.
- Valid/ready request and response channels.

---
 rtl/mod_inverse_unit.sv | 164 ++++++++++++++++
 tb/tb_mod_inverse_unit.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_inverse_unit.sv
// mod_inverse_unit
//   Sequential modular-inverse engine. For an odd modulus m >= 3 and
//   0 < a < m it returns x in [1, m-1] with (a*x) mod m == 1. It uses the
//   binary extended-Euclid method, so the datapath is shifts, compares and
//   add/subtract only, with no divider.
//
// Ports
//   clk        : clock
//   reset      : synchronous, active-high reset; aborts any computation
//   req_valid  : request present
//   req_ready  : unit can accept a request (IDLE only)
//   req_a      : value to invert (sampled on acceptance only)
//   req_m      : modulus (sampled on acceptance only)
//   rsp_valid  : result available (DONE)
//   rsp_ready  : consumer accepts the result
//   rsp_result : inverse, or 0 when rsp_err is set
//   rsp_err    : no inverse exists or the operands are illegal
//   busy       : computation in progress (RUN)
module mod_inverse_unit #(
   parameter int WIDTH = 128
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_m,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_err,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] u_reg, u_next;
   logic [WIDTH-1:0] v_reg, v_next;
   logic [WIDTH-1:0] x1_reg, x1_next;
   logic [WIDTH-1:0] x2_reg, x2_next;
   logic [WIDTH-1:0] m_reg, m_next;
   logic [WIDTH-1:0] result_reg, result_next;
   logic             err_reg, err_next;
   logic             illegal;

   // x/2 mod m for odd m: when x is odd, x+m is even and still < 2m, so the
   // sum needs one extra bit before the shift brings it back into range.
   function automatic logic [WIDTH-1:0] half_mod(input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] m);
      logic [WIDTH:0] s;
      s = x[0] ? ({1'b0, x} + {1'b0, m}) : {1'b0, x};
      return WIDTH'(s >> 1);
   endfunction

   // (x - y) mod m with both operands already in [0, m-1].
   function automatic logic [WIDTH-1:0] sub_mod(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y,
                                                input logic [WIDTH-1:0] m);
      logic [WIDTH:0] s;
      s = (x >= y) ? ({1'b0, x} - {1'b0, y})
                   : ({1'b0, x} + {1'b0, m} - {1'b0, y});
      return WIDTH'(s);
   endfunction

   assign illegal = (req_a == '0) || (req_a >= req_m) || !req_m[0] ||
                    (req_m < WIDTH'(3));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg  <= IDLE;
         u_reg      <= '0;
         v_reg      <= '0;
         x1_reg     <= '0;
         x2_reg     <= '0;
         m_reg      <= '0;
         result_reg <= '0;
         err_reg    <= 1'b0;
      end else begin
         state_reg  <= state_next;
         u_reg      <= u_next;
         v_reg      <= v_next;
         x1_reg     <= x1_next;
         x2_reg     <= x2_next;
         m_reg      <= m_next;
         result_reg <= result_next;
         err_reg    <= err_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      u_next      = u_reg;
      v_next      = v_reg;
      x1_next     = x1_reg;
      x2_next     = x2_reg;
      m_next      = m_reg;
      result_next = result_reg;
      err_next    = err_reg;

      case (state_reg)
         IDLE: begin
            if (req_valid) begin
               m_next = req_m;
               if (illegal) begin
                  result_next = '0;
                  err_next    = 1'b1;
                  state_next  = DONE;
               end else begin
                  u_next     = req_a;
                  v_next     = req_m;
                  x1_next    = WIDTH'(1);
                  x2_next    = '0;
                  state_next = RUN;
               end
            end
         end

         // Invariants: x1*a == u and x2*a == v (mod m). The first matching
         // rule wins, so the termination tests precede the reductions.
         RUN: begin
            if (u_reg == WIDTH'(1)) begin
               result_next = x1_reg;
               err_next    = 1'b0;
               state_next  = DONE;
            end else if (v_reg == WIDTH'(1)) begin
               result_next = x2_reg;
               err_next    = 1'b0;
               state_next  = DONE;
            end else if (u_reg == '0 || v_reg == '0) begin
               // u == v happened earlier: gcd(a, m) > 1
               result_next = '0;
               err_next    = 1'b1;
               state_next  = DONE;
            end else if (!u_reg[0]) begin
               u_next  = u_reg >> 1;
               x1_next = half_mod(x1_reg, m_reg);
            end else if (!v_reg[0]) begin
               v_next  = v_reg >> 1;
               x2_next = half_mod(x2_reg, m_reg);
            end else if (u_reg >= v_reg) begin
               u_next  = u_reg - v_reg;
               x1_next = sub_mod(x1_reg, x2_reg, m_reg);
            end else begin
               v_next  = v_reg - u_reg;
               x2_next = sub_mod(x2_reg, x1_reg, m_reg);
            end
         end

         DONE: begin
            if (rsp_ready) state_next = IDLE;
         end

         default: state_next = IDLE;
      endcase
   end

   assign req_ready  = (state_reg == IDLE);
   assign busy       = (state_reg == RUN);
   assign rsp_valid  = (state_reg == DONE);
   assign rsp_result = result_reg;
   assign rsp_err    = err_reg;

endmodule

// File: tb/tb_mod_inverse_unit.sv
// tb_mod_inverse_unit
//   Directed and random-sweep bench for mod_inverse_unit. Expected results
//   come from a division-based extended-Euclid model; a monitor compares
//   every cycle on which a response is presented.
module tb_mod_inverse_unit;
   localparam int W     = 128;
   localparam int LAT   = 4 * W + 2;
   localparam int N_RND = 300;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         req_valid = 1'b0;
   logic         req_ready;
   logic [W-1:0] req_a = '0;
   logic [W-1:0] req_m = '0;
   logic         rsp_valid;
   logic         rsp_ready = 1'b0;
   logic [W-1:0] rsp_result;
   logic         rsp_err;
   logic         busy;

   int n_checks = 0;
   int n_fail   = 0;
   int n_txn    = 0;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] m;
      logic [W-1:0] res;
      logic         err;
   } exp_t;
   exp_t exp_q[$];

   mod_inverse_unit #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_m(req_m), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_err(rsp_err), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: ordinary extended Euclid with quotients, coefficients kept mod m.
   function automatic void ref_inv(input logic [W-1:0] a, input logic [W-1:0] m,
                                   output logic [W-1:0] res, output logic err);
      logic [2*W-1:0] r0, r1, t0, t1, q, tmp, mm;
      res = '0;
      err = 1'b1;
      if (a == '0 || a >= m || !m[0] || m < 3) return;
      mm = {{W{1'b0}}, m};
      r0 = mm;
      r1 = {{W{1'b0}}, a};
      t0 = '0;
      t1 = 1;
      while (r1 != 0) begin
         q   = r0 / r1;
         tmp = r0 - q * r1;
         r0  = r1;
         r1  = tmp;
         tmp = (t0 + mm - (q * t1) % mm) % mm;
         t0  = t1;
         t1  = tmp;
      end
      if (r0 == 1) begin
         res = t0[W-1:0];
         err = 1'b0;
      end
   endfunction

   function automatic logic [W-1:0] mul_mod(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [W-1:0] m);
      logic [2*W-1:0] p;
      p = ({{W{1'b0}}, a} * {{W{1'b0}}, b}) % {{W{1'b0}}, m};
      return p[W-1:0];
   endfunction

   // Response monitor: every presented response must match the oldest
   // outstanding request, and stay matching while backpressured.
   always @(negedge clk) begin
      if (!reset && rsp_valid) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_rsp: got result %0h err %0b expected no response", rsp_result, rsp_err);
         end else begin
            check("rsp_result", rsp_result, exp_q[0].res);
            check("rsp_err", W'(rsp_err), W'(exp_q[0].err));
            if (!exp_q[0].err)
               check("a_times_result_mod_m", mul_mod(exp_q[0].a, rsp_result, exp_q[0].m), W'(1));
            if (rsp_ready) begin
               n_txn++;
               $display("txn %0d: a=%0h m=%0h -> result=%0h err=%0b", n_txn,
                        exp_q[0].a, exp_q[0].m, rsp_result, rsp_err);
               void'(exp_q.pop_front());
            end
         end
      end
   end

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req_ready"}, W'(req_ready), W'(1));
      check({tag, "_rsp_valid"}, W'(rsp_valid), W'(0));
      check({tag, "_rsp_result"}, rsp_result, W'(0));
      check({tag, "_rsp_err"}, W'(rsp_err), W'(0));
      check({tag, "_busy"}, W'(busy), W'(0));
   endtask

   task automatic accept(input logic [W-1:0] a, input logic [W-1:0] m);
      exp_t e;
      int   guard = 0;
      while (!req_ready && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      check("req_ready_before_accept", W'(req_ready), W'(1));
      e.a = a;
      e.m = m;
      ref_inv(a, m, e.res, e.err);
      exp_q.push_back(e);
      req_valid = 1'b1;
      req_a     = a;
      req_m     = m;
      @(posedge clk); #1;
      // Inputs after acceptance must be ignored.
      req_valid = 1'b0;
      req_a     = {$urandom, $urandom, $urandom, $urandom};
      req_m     = {$urandom, $urandom, $urandom, $urandom};
   endtask

   // Returns cycles from acceptance to rsp_valid; 0 on hang (unit is reset).
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] m, output int lat);
      accept(a, m);
      lat = 1;
      while (!rsp_valid && lat < LAT) begin
         if (lat == 1 || lat % 64 == 0) begin
            check("busy_in_run", W'(busy), W'(1));
            check("req_ready_in_run", W'(req_ready), W'(0));
         end
         @(posedge clk); #1;
         lat++;
      end
      if (!rsp_valid) begin
         n_checks++;
         n_fail++;
         $display("FAIL hang: got no rsp_valid after %0d cycles expected at most %0d", lat, LAT);
         reset = 1'b1;
         exp_q.delete();
         @(posedge clk); #1;
         reset = 1'b0;
         lat = 0;
      end
   endtask

   task automatic respond(input int delay);
      rsp_ready = 1'b0;
      repeat (delay) begin
         @(posedge clk); #1;
         check("hold_rsp_valid", W'(rsp_valid), W'(1));
         check("hold_req_ready", W'(req_ready), W'(0));
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      check("post_hs_rsp_valid", W'(rsp_valid), W'(0));
      check("post_hs_req_ready", W'(req_ready), W'(1));
   endtask

   initial begin
      logic [W-1:0] m127, r, m, a, mask;
      logic         e;
      int           lat, nb;

      m127 = '0;
      m127[W-2:0] = '1;

      // Model pinned against hand-computed values.
      ref_inv(W'(3), W'(7), r, e);
      check("model_3_7", r, W'(5));
      ref_inv(W'(2), m127, r, e);
      check("model_2_m127", r, W'(1) << 126);
      ref_inv(W'(6), W'(9), r, e);
      check("model_6_9_err", W'(e), W'(1));
      ref_inv(W'(1), W'(11), r, e);
      check("model_1_11", r, W'(1));
      ref_inv(W'(7), W'(7), r, e);
      check("model_7_7_err", W'(e), W'(1));

      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      check_reset_outputs("reset");

      issue(W'(3), W'(7), lat);
      check("a3m7_result", rsp_result, W'(5));
      check("a3m7_err", W'(rsp_err), W'(0));
      respond(2);

      issue(W'(2), m127, lat);
      check("a2m127_result", rsp_result, W'(1) << 126);
      respond(0);

      issue(W'(6), W'(9), lat);
      check("a6m9_err", W'(rsp_err), W'(1));
      check("a6m9_result", rsp_result, W'(0));
      respond(1);

      issue(W'(0), W'(7), lat);
      check("a0m7_latency", W'(lat), W'(1));
      check("a0m7_err", W'(rsp_err), W'(1));
      respond(0);
      issue(W'(7), W'(7), lat);
      check("a7m7_latency", W'(lat), W'(1));
      check("a7m7_err", W'(rsp_err), W'(1));
      respond(0);
      issue(W'(3), W'(8), lat);
      check("m8_latency", W'(lat), W'(1));
      check("m8_err", W'(rsp_err), W'(1));
      check("m8_result", rsp_result, W'(0));
      respond(0);
      issue(W'(0), W'(1), lat);
      check("m1_latency", W'(lat), W'(1));
      check("m1_err", W'(rsp_err), W'(1));
      respond(0);

      issue(W'(1), W'(11), lat);
      check("a1m11_latency", W'(lat), W'(2));
      check("a1m11_result", rsp_result, W'(1));
      respond(10);

      // Reset in the middle of RUN drops the computation silently.
      accept(W'(2), m127);
      check("mid_reset_busy", W'(busy), W'(1));
      reset = 1'b1;
      exp_q.delete();
      @(posedge clk); #1;
      reset = 1'b0;
      check_reset_outputs("mid_reset");
      repeat (10) begin
         @(posedge clk); #1;
         check("no_rsp_after_reset", W'(rsp_valid), W'(0));
      end

      issue(W'(3), W'(7), lat);
      check("fresh_3_7_result", rsp_result, W'(5));
      respond(0);

      for (int i = 0; i < N_RND; i++) begin
         nb = (i % 15 == 0) ? W : $urandom_range(2, 20);
         mask = '1;
         mask = mask >> (W - nb);
         m = {$urandom, $urandom, $urandom, $urandom} & mask;
         m[nb-1] = 1'b1;
         m[0] = 1'b1;
         if (m < 3) m = W'(3);
         a = {$urandom, $urandom, $urandom, $urandom} % m;
         if (a == '0) a = W'(1);
         issue(a, m, lat);
         if (lat != 0) respond($urandom_range(0, 3));
      end

      repeat (2) @(posedge clk);
      check("queue_drained", W'(exp_q.size()), W'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
